// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants, channel slice helper and dead-time state encoding
// Maximum supported WIDTH is 64 and CHANNELS*WIDTH at most BUS_MAX.
package pwm_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam int BUS_MAX = 1024;
  typedef enum logic [1:0] {DT_LOW_ON, DT_GAP, DT_HIGH_ON} dt_state_e;
  function automatic logic [63:0] chan_slice(input logic [BUS_MAX-1:0] bus, input int i, input int w);
    return 64'(bus >> (i * w));
  endfunction
endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: dead-time stage for one channel, complementary high/low outputs
// Ports: CLK, RST_N (async active-low), raw (compare output), hi (high side), lo (low side).
// Every raw transition forces both sides off for DEADTIME cycles; a raw change
// during the gap restarts it, so pulses shorter than DEADTIME never assert.
module pwm_deadtime import pwm_pkg::*; #(
  parameter int DEADTIME = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic raw,
  output logic hi,
  output logic lo
);
  localparam logic [7:0] GAP_LAST = 8'(DEADTIME - 1);
  dt_state_e state_q, state_d;
  logic tgt_q, tgt_d;
  logic [7:0] gap_q, gap_d;
  always_comb begin
    state_d = state_q;
    tgt_d = tgt_q;
    gap_d = gap_q;
    case (state_q)
      DT_LOW_ON: if (raw) begin
        state_d = DT_GAP;
        tgt_d = 1'b1;
        gap_d = '0;
      end
      DT_HIGH_ON: if (!raw) begin
        state_d = DT_GAP;
        tgt_d = 1'b0;
        gap_d = '0;
      end
      default: if (raw != tgt_q) begin
        tgt_d = raw;
        gap_d = '0;
      end else if (gap_q == GAP_LAST) begin
        state_d = tgt_q ? DT_HIGH_ON : DT_LOW_ON;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    endcase
    hi = state_q == DT_HIGH_ON;
    lo = state_q == DT_LOW_ON;
  end
  // Reset lands in the gap heading low, so lo asserts DEADTIME cycles after release.
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q <= DT_GAP;
      tgt_q <= 1'b0;
      gap_q <= '0;
    end else begin
      state_q <= state_d;
      tgt_q <= tgt_d;
      gap_q <= gap_d;
    end
endmodule

// File: rtl/pwm_gen_mc.sv
// pwm_gen_mc: multi-channel edge-aligned PWM with double-buffered duty/period
// Ports: CLK, RST_N (async active-low), CE (count enable), DUTY (per-channel duty),
//   TOP (period terminal count), LOAD (shadow capture strobe), CNT (counter),
//   PWM (outputs / high side), PERIOD_END (wrap pulse), PWM_L (low side, optional).
// Macro PWM_DEADTIME_EN adds a dead-time stage per channel and the PWM_L port.
module pwm_gen_mc import pwm_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHANNELS = 3,
  parameter int DEADTIME = 4
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      CE,
  input  logic [CHANNELS*WIDTH-1:0] DUTY,
  input  logic [WIDTH-1:0]          TOP,
  input  logic                      LOAD,
  output logic [WIDTH-1:0]          CNT,
  output logic [CHANNELS-1:0]       PWM,
  output logic                      PERIOD_END
`ifdef PWM_DEADTIME_EN
  ,
  output logic [CHANNELS-1:0]       PWM_L
`endif
);
  if (DEADTIME < 1 || DEADTIME > 255 || WIDTH > 64 || CHANNELS * WIDTH > BUS_MAX) begin : g_bad_param
    $error("pwm_gen_mc: parameter out of range");
  end
  logic [WIDTH-1:0] cnt_q, cnt_d, sh_top_q, sh_top_d, act_top_q, act_top_d;
  logic [CHANNELS*WIDTH-1:0] sh_duty_q, sh_duty_d, act_duty_q, act_duty_d;
  logic [CHANNELS-1:0] raw_q, raw_d;
  logic pend_q, pend_d, pe_q, pe_d, wrap;
  // A LOAD on the wrap edge bypasses the shadow and goes straight to active.
  always_comb begin
    wrap = CE && (cnt_q == act_top_q);
    cnt_d = !CE ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
    sh_duty_d = LOAD ? DUTY : sh_duty_q;
    sh_top_d = LOAD ? TOP : sh_top_q;
    pend_d = !wrap && (LOAD || pend_q);
    act_duty_d = !wrap ? act_duty_q : LOAD ? DUTY : pend_q ? sh_duty_q : act_duty_q;
    act_top_d = !wrap ? act_top_q : LOAD ? TOP : pend_q ? sh_top_q : act_top_q;
    pe_d = wrap;
    // Compare against next-state values so PWM lines up with the CNT it belongs to.
    for (int i = 0; i < CHANNELS; i++)
      raw_d[i] = CE ? cnt_d < WIDTH'(chan_slice(BUS_MAX'(act_duty_d), i, WIDTH)) : raw_q[i];
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      cnt_q <= '0;
      sh_top_q <= '1;
      act_top_q <= '1;
      sh_duty_q <= '0;
      act_duty_q <= '0;
      raw_q <= '0;
      pend_q <= 1'b0;
      pe_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sh_top_q <= sh_top_d;
      act_top_q <= act_top_d;
      sh_duty_q <= sh_duty_d;
      act_duty_q <= act_duty_d;
      raw_q <= raw_d;
      pend_q <= pend_d;
      pe_q <= pe_d;
    end
  assign CNT = cnt_q;
  assign PERIOD_END = pe_q;
`ifdef PWM_DEADTIME_EN
  for (genvar g = 0; g < CHANNELS; g++) begin : g_dt
    pwm_deadtime #(.DEADTIME(DEADTIME)) u_dt (
      .CLK(CLK),
      .RST_N(RST_N),
      .raw(raw_q[g]),
      .hi(PWM[g]),
      .lo(PWM_L[g])
    );
  end
`else
  assign PWM = raw_q;
`endif
endmodule
